// File: rtl/fifo_pkg.sv
// Shared types and helpers for the sync_fifo_prog family.
//   fifo_status_t   : registered occupancy and sticky error flags
//   FIFO_STATUS_RST : flag values after aclr_n / sclr_n
//   ptr_inc()       : pointer increment that wraps at an arbitrary depth
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  localparam fifo_status_t FIFO_STATUS_RST = '{
    full:         1'b0,
    empty:        1'b1,
    almost_full:  1'b0,
    almost_empty: 1'b1,
    overflow:     1'b0,
    underflow:    1'b0
  };

  // Explicit wrap so non-power-of-two depths never address past DEPTH-1.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Register-file storage for sync_fifo_prog.
//   clk     : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data (data, plus parity bit when compiled in)
//   raddr_i : asynchronous read address
//   rdata_o : asynchronous read data
module fifo_ram #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;

  // Storage has no reset; contents are don't-care after any clear.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// optional show-ahead read, arbitrary depth and sticky error flags.
// Optional feature: define SYNC_FIFO_PARITY_EN to store and check even parity.
//   clk, aclr_n (async, active-low), sclr_n (sync, active-low)
//   din, wr_en        : write side
//   rd_en, dout       : read side (dout registered, or combinational in show-ahead)
//   clr_err           : clears overflow/underflow/parity_err
//   full, empty, almost_full, almost_empty, usedw : occupancy
//   overflow, underflow, parity_err : sticky errors
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AF_THRESH  = DEPTH - 2,
  parameter int unsigned AE_THRESH  = 2,
  parameter int unsigned SHOW_AHEAD = 0
) (
  input  logic                         clk,
  input  logic                         aclr_n,
  input  logic                         sclr_n,
  input  logic [DATA_WIDTH-1:0]        din,
  input  logic                         wr_en,
  input  logic                         rd_en,
  input  logic                         clr_err,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   usedw,
  output logic                         overflow,
  output logic                         underflow,
  output logic                         parity_err
);

`ifdef SYNC_FIFO_PARITY_EN
  localparam int unsigned MEM_W = DATA_WIDTH + 1;
`else
  localparam int unsigned MEM_W = DATA_WIDTH;
`endif
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] usedw_q, usedw_d;
  fifo_status_t     status_q, status_d;

  logic             rd_allow_c;
  logic             wr_allow_c;
  logic [MEM_W-1:0] wdata_c;
  logic [MEM_W-1:0] rd_word_c;

  // A write at full is allowed only when a read frees a slot in the same cycle.
  assign rd_allow_c = rd_en && !status_q.empty;
  assign wr_allow_c = wr_en && (!status_q.full || rd_allow_c);

`ifdef SYNC_FIFO_PARITY_EN
  assign wdata_c = {^din, din};
`else
  assign wdata_c = din;
`endif

  fifo_ram #(
    .WIDTH  (MEM_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_allow_c && sclr_n),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata_c),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_word_c)
  );

  // Next-state for pointers, count and flags; sclr_n overrides everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usedw_d  = usedw_q;
    status_d = status_q;

    if (wr_allow_c) wr_ptr_d = PTR_W'(ptr_inc(32'(wr_ptr_q), DEPTH));
    if (rd_allow_c) rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q), DEPTH));

    case ({wr_allow_c, rd_allow_c})
      2'b10:   usedw_d = usedw_q + CNT_W'(1);
      2'b01:   usedw_d = usedw_q - CNT_W'(1);
      default: usedw_d = usedw_q;
    endcase

    // Flags follow usedw_d so they line up with usedw every cycle.
    status_d.full         = (usedw_d == CNT_W'(DEPTH));
    status_d.empty        = (usedw_d == CNT_W'(0));
    status_d.almost_full  = (usedw_d >= CNT_W'(AF_THRESH));
    status_d.almost_empty = (usedw_d <= CNT_W'(AE_THRESH));

    // Error events in the clr_err cycle still win.
    if (clr_err) begin
      status_d.overflow  = 1'b0;
      status_d.underflow = 1'b0;
    end
    if (wr_en && !wr_allow_c) status_d.overflow  = 1'b1;
    if (rd_en && status_q.empty) status_d.underflow = 1'b1;

    if (!sclr_n) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usedw_d  = '0;
      status_d = FIFO_STATUS_RST;
    end
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      status_q <= FIFO_STATUS_RST;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
      status_q <= status_d;
    end
  end

  // Read data path: show-ahead exposes the head word directly.
  if (SHOW_AHEAD != 0) begin : g_show_ahead
    assign dout = rd_word_c[DATA_WIDTH-1:0];
  end else begin : g_normal
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    always_comb begin
      dout_d = dout_q;
      if (rd_allow_c) dout_d = rd_word_c[DATA_WIDTH-1:0];
      if (!sclr_n)    dout_d = '0;
    end

    always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) dout_q <= '0;
      else         dout_q <= dout_d;
    end

    assign dout = dout_q;
  end

`ifdef SYNC_FIFO_PARITY_EN
  logic parity_err_q, parity_err_d;

  // Stored word carries even parity, so the XOR of the whole word must be 0.
  always_comb begin
    parity_err_d = parity_err_q;
    if (clr_err)                      parity_err_d = 1'b0;
    if (rd_allow_c && (^rd_word_c))   parity_err_d = 1'b1;
    if (!sclr_n)                      parity_err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) parity_err_q <= 1'b0;
    else         parity_err_q <= parity_err_d;
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign usedw        = usedw_q;
  assign full         = status_q.full;
  assign empty        = status_q.empty;
  assign almost_full  = status_q.almost_full;
  assign almost_empty = status_q.almost_empty;
  assign overflow     = status_q.overflow;
  assign underflow    = status_q.underflow;

endmodule
